// File: rtl/mem_arbiter_if.sv
// Requester and Memory signals shared by the unified-memory arbiter
// and its surroundings (fetch unit, load/store unit, Memory).
interface mem_arbiter_if;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_ack;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [31:0] d_rdata;
    logic        d_ack;
    logic [31:0] mem_addr;
    logic [31:0] mem_din;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_dout;
    logic        busy;

    modport slave (
        input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_dout,
        output if_rdata, if_ack, d_rdata, d_ack,
        output mem_addr, mem_din, mem_read, mem_write, busy
    );

    modport master (
        output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_dout,
        input  if_rdata, if_ack, d_rdata, d_ack,
        input  mem_addr, mem_din, mem_read, mem_write, busy
    );
endinterface

// File: rtl/mem_arbiter.sv
// Shares the unified Memory between instruction fetch and data access,
// one latched request at a time, with a starvation guard for fetch.
module mem_arbiter #(
    parameter int unsigned LATENCY      = 2,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic         clk,
    input  logic         reset,
    mem_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    localparam logic [3:0] WAIT_INIT  = 4'(LATENCY - 1);
    localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

    state_t      state;
    state_t      state_nxt;
    logic [3:0]  wait_cnt;
    logic [3:0]  starve_cnt;
    logic        owner_d;
    logic        we_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] if_rdata_q;
    logic [31:0] d_rdata_q;
    logic        grant_if;
    logic        grant_d;
    logic        last;

    assign last = (wait_cnt == 4'd0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt     = state;
        grant_if      = 1'b0;
        grant_d       = 1'b0;
        bus.mem_read  = 1'b0;
        bus.mem_write = 1'b0;
        bus.if_ack    = 1'b0;
        bus.d_ack     = 1'b0;
        bus.busy      = 1'b1;
        unique case (state)
            IDLE: begin
                bus.busy = 1'b0;
                // Data wins ties until fetch has waited STARVE_LIMIT grants
                if (bus.d_req && !(bus.if_req && starve_cnt == STARVE_MAX))
                    grant_d = 1'b1;
                else if (bus.if_req)
                    grant_if = 1'b1;
                if (grant_if || grant_d)
                    state_nxt = ACCESS;
            end
            ACCESS: begin
                bus.mem_read  = ~we_q;
                bus.mem_write = we_q & last;
                if (last)
                    state_nxt = RESP;
            end
            RESP: begin
                bus.if_ack = ~owner_d;
                bus.d_ack  = owner_d;
                state_nxt  = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wait_cnt   <= 4'd0;
            starve_cnt <= 4'd0;
            owner_d    <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= 32'd0;
            wdata_q    <= 32'd0;
            if_rdata_q <= 32'd0;
            d_rdata_q  <= 32'd0;
        end else begin
            if (grant_d) begin
                owner_d  <= 1'b1;
                we_q     <= bus.d_we;
                addr_q   <= bus.d_addr;
                wdata_q  <= bus.d_wdata;
                wait_cnt <= WAIT_INIT;
            end else if (grant_if) begin
                owner_d  <= 1'b0;
                we_q     <= 1'b0;
                addr_q   <= bus.if_addr;
                wait_cnt <= WAIT_INIT;
            end else if (state == ACCESS && !last) begin
                wait_cnt <= wait_cnt - 4'd1;
            end

            if (state == ACCESS && last && !we_q) begin
                if (owner_d) d_rdata_q  <= bus.mem_dout;
                else         if_rdata_q <= bus.mem_dout;
            end

            if (state == IDLE) begin
                if (grant_if || !bus.if_req)
                    starve_cnt <= 4'd0;
                else if (grant_d && starve_cnt != STARVE_MAX)
                    starve_cnt <= starve_cnt + 4'd1;
            end
        end
    end

    assign bus.mem_addr = addr_q;
    assign bus.mem_din  = wdata_q;
    assign bus.if_rdata = if_rdata_q;
    assign bus.d_rdata  = d_rdata_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed and randomized checks of mem_arbiter against a word-level
// memory image and transaction-order rules.
module tb_mem_arbiter;
    localparam int LAT = 2;
    localparam int SL  = 4;

    logic clk = 1'b0;
    logic reset;
    logic seed_mem;
    int   n_checks = 0;
    int   n_err    = 0;
    int   step     = 0;

    logic [31:0] mem     [256];
    logic [31:0] ref_mem [256];
    logic [31:0] exp_if;
    logic [31:0] exp_d;

    mem_arbiter_if bus();

    mem_arbiter #(.LATENCY(LAT), .STARVE_LIMIT(SL)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] seed(int i);
        if (i == 0) return 32'h00500093;
        return (32'(i) * 32'h01010101) ^ 32'hA5000000;
    endfunction

    function automatic int widx(logic [31:0] a);
        return int'(a[9:2]);
    endfunction

    always @(posedge clk) begin
        if (seed_mem) begin
            for (int i = 0; i < 256; i++) mem[i] <= seed(i);
        end else if (bus.mem_write) begin
            mem[bus.mem_addr[9:2]] <= bus.mem_din;
        end
    end
    assign bus.mem_dout = mem[bus.mem_addr[9:2]];

    task automatic cyc();
        @(posedge clk);
        #1;
        step++;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chkb(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: got %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic run_txn(input string tag, input bit is_d, input bit we,
                           input logic [31:0] addr, input logic [31:0] wdata);
        int n, reads, writes, bad;
        bit other, got;
        n = 0; reads = 0; writes = 0; bad = 0; other = 0; got = 0;
        if (is_d) begin
            bus.d_req = 1'b1; bus.d_we = we;
            bus.d_addr = addr; bus.d_wdata = wdata;
        end else begin
            bus.if_req = 1'b1; bus.if_addr = addr;
        end
        while (!got && n < 40) begin
            cyc();
            n++;
            reads  += int'(bus.mem_read);
            writes += int'(bus.mem_write);
            if ((bus.mem_read || bus.mem_write) && bus.mem_addr !== addr) bad++;
            if (bus.mem_write && bus.mem_din !== wdata) bad++;
            got = is_d ? bus.d_ack : bus.if_ack;
            if (is_d ? bus.if_ack : bus.d_ack) other = 1'b1;
        end
        if (is_d) bus.d_req = 1'b0;
        else      bus.if_req = 1'b0;
        if (we) ref_mem[widx(addr)] = wdata;
        else if (is_d) exp_d = ref_mem[widx(addr)];
        else exp_if = ref_mem[widx(addr)];
        chk({tag, "_lat"}, 32'(n), 32'(LAT + 1));
        chk({tag, "_reads"}, 32'(reads), we ? 32'd0 : 32'(LAT));
        chk({tag, "_writes"}, 32'(writes), we ? 32'd1 : 32'd0);
        chk({tag, "_busaddr"}, 32'(bad), 32'd0);
        chkb({tag, "_otherack"}, other, 1'b0);
        chk({tag, "_if_rdata"}, bus.if_rdata, exp_if);
        chk({tag, "_d_rdata"}, bus.d_rdata, exp_d);
        cyc();
        chkb({tag, "_idle"}, bus.busy, 1'b0);
    endtask

    initial begin
        int t_d, t_i, nacks, last, m_starve, if_start, d_start;
        int store_acks, wr_pulses, if_wait_max;
        bit exp_win_d, if_pend, d_pend, dwe;
        logic [31:0] ia, da, dw;

        for (int i = 0; i < 256; i++) ref_mem[i] = seed(i);
        exp_if = 32'd0; exp_d = 32'd0;
        reset = 1'b1; seed_mem = 1'b1;
        bus.if_req = 1'b0; bus.if_addr = 32'd0;
        bus.d_req = 1'b0; bus.d_we = 1'b0;
        bus.d_addr = 32'd0; bus.d_wdata = 32'd0;
        cyc(); cyc(); cyc();
        chkb("rst_busy", bus.busy, 1'b0);
        chkb("rst_rd", bus.mem_read, 1'b0);
        chkb("rst_wr", bus.mem_write, 1'b0);
        chkb("rst_ack", bus.if_ack | bus.d_ack, 1'b0);
        chk("rst_if_rdata", bus.if_rdata, 32'd0);
        chk("rst_d_rdata", bus.d_rdata, 32'd0);
        chk("rst_addr", bus.mem_addr, 32'd0);
        chk("rst_din", bus.mem_din, 32'd0);
        seed_mem = 1'b0;
        reset = 1'b0;
        cyc();

        run_txn("fetch0", 1'b0, 1'b0, 32'h0, 32'h0);
        chk("fetch0_word", bus.if_rdata, 32'h00500093);
        run_txn("store100", 1'b1, 1'b1, 32'h100, 32'hDEADBEEF);
        run_txn("load100", 1'b1, 1'b0, 32'h100, 32'h0);
        chk("load100_word", bus.d_rdata, 32'hDEADBEEF);

        // Simultaneous requests: D first, IF one full period later
        bus.if_req = 1'b1; bus.if_addr = 32'h8;
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h104;
        t_d = -1; t_i = -1;
        for (int k = 1; k <= 40 && (t_d < 0 || t_i < 0); k++) begin
            cyc();
            if (bus.d_ack) begin t_d = k; bus.d_req = 1'b0; end
            if (bus.if_ack) begin t_i = k; bus.if_req = 1'b0; end
        end
        chk("both_d_first", 32'(t_d), 32'(LAT + 1));
        chk("both_if_gap", 32'(t_i - t_d), 32'(LAT + 2));
        exp_d = ref_mem[widx(32'h104)]; exp_if = ref_mem[widx(32'h8)];
        chk("both_d_data", bus.d_rdata, exp_d);
        chk("both_if_data", bus.if_rdata, exp_if);
        cyc(); cyc();

        // Both held: D wins SL times in a row, then IF, repeating
        bus.if_req = 1'b1; bus.if_addr = 32'h10;
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h100;
        m_starve = 0; nacks = 0; last = step;
        for (int k = 0; k < 300 && nacks < 2 * (SL + 1); k++) begin
            cyc();
            if (bus.if_ack || bus.d_ack) begin
                exp_win_d = (m_starve < SL);
                m_starve = exp_win_d ? m_starve + 1 : 0;
                chkb("starve_winner", bus.d_ack, exp_win_d);
                chkb("starve_excl", bus.if_ack, ~bus.d_ack);
                if (nacks > 0) chk("starve_period", 32'(step - last), 32'(LAT + 2));
                last = step;
                nacks++;
                if (bus.d_ack) exp_d = ref_mem[widx(32'h100)];
                else exp_if = ref_mem[widx(32'h10)];
                chk("starve_d_data", bus.d_rdata, exp_d);
                chk("starve_if_data", bus.if_rdata, exp_if);
            end
        end
        chk("starve_acks", 32'(nacks), 32'(2 * (SL + 1)));
        bus.if_req = 1'b0; bus.d_req = 1'b0;
        cyc(); cyc();

        // Reset in the final ACCESS cycle of a store
        bus.d_req = 1'b1; bus.d_we = 1'b1;
        bus.d_addr = 32'h200; bus.d_wdata = 32'h12345678;
        cyc(); cyc();
        reset = 1'b1;
        #1;
        chkb("midrst_wr", bus.mem_write, 1'b0);
        chkb("midrst_busy", bus.busy, 1'b0);
        chkb("midrst_ack", bus.d_ack | bus.if_ack, 1'b0);
        chk("midrst_addr", bus.mem_addr, 32'd0);
        chk("midrst_din", bus.mem_din, 32'd0);
        chk("midrst_d_rdata", bus.d_rdata, 32'd0);
        chk("midrst_if_rdata", bus.if_rdata, 32'd0);
        exp_d = 32'd0; exp_if = 32'd0;
        cyc(); cyc();
        reset = 1'b0;
        chk("midrst_nowrite", mem[widx(32'h200)], ref_mem[widx(32'h200)]);
        run_txn("restart", 1'b1, 1'b1, 32'h200, 32'h12345678);
        run_txn("reload", 1'b1, 1'b0, 32'h200, 32'h0);

        // Fetch held across ack: back-to-back period
        bus.if_req = 1'b1; bus.if_addr = 32'h20;
        nacks = 0; last = step;
        for (int k = 0; k < 60 && nacks < 3; k++) begin
            cyc();
            if (bus.if_ack) begin
                exp_if = ref_mem[widx(bus.if_addr)];
                chk("b2b_data", bus.if_rdata, exp_if);
                if (nacks > 0) chk("b2b_period", 32'(step - last), 32'(LAT + 2));
                last = step;
                nacks++;
                bus.if_addr = bus.if_addr + 32'd4;
            end
        end
        chk("b2b_acks", 32'(nacks), 32'd3);
        bus.if_req = 1'b0;
        cyc(); cyc();

        // Randomized traffic from both requesters
        if_pend = 1'b0; d_pend = 1'b0; m_starve = 0;
        store_acks = 0; wr_pulses = 0; if_start = 0; d_start = 0;
        ia = 32'd0; da = 32'd0; dw = 32'd0; dwe = 1'b0;
        if_wait_max = (SL + 1) * (LAT + 2) + LAT + 2;
        for (int k = 0; k < 800; k++) begin
            if (k >= 600 && !if_pend && !d_pend) break;
            if (k < 600 && !if_pend && $urandom_range(0, 2) == 0) begin
                ia = {22'd0, 8'($urandom_range(0, 255)), 2'b00};
                bus.if_req = 1'b1; bus.if_addr = ia;
                if_pend = 1'b1; if_start = step;
            end
            if (k < 600 && !d_pend && $urandom_range(0, 2) == 0) begin
                da = {22'd0, 8'($urandom_range(0, 255)), 2'b00};
                dw = $urandom;
                dwe = 1'($urandom_range(0, 1));
                bus.d_req = 1'b1; bus.d_we = dwe;
                bus.d_addr = da; bus.d_wdata = dw;
                d_pend = 1'b1; d_start = step;
            end
            cyc();
            wr_pulses += int'(bus.mem_write);
            if (bus.if_ack || bus.d_ack)
                chkb("rnd_excl", bus.if_ack & bus.d_ack, 1'b0);
            if (bus.d_ack) begin
                chkb("rnd_d_expected", d_pend, 1'b1);
                if (if_pend && if_start < step - LAT) m_starve++;
                else m_starve = 0;
                chkb("rnd_starve", m_starve <= SL, 1'b1);
                if (dwe) begin
                    ref_mem[widx(da)] = dw;
                    store_acks++;
                end else begin
                    exp_d = ref_mem[widx(da)];
                end
                chk("rnd_d_rdata", bus.d_rdata, exp_d);
                chk("rnd_d_if_rdata", bus.if_rdata, exp_if);
                d_pend = 1'b0; bus.d_req = 1'b0;
            end
            if (bus.if_ack) begin
                chkb("rnd_if_expected", if_pend, 1'b1);
                chkb("rnd_if_wait", (step - if_start) <= if_wait_max, 1'b1);
                m_starve = 0;
                exp_if = ref_mem[widx(ia)];
                chk("rnd_if_rdata", bus.if_rdata, exp_if);
                chk("rnd_if_d_rdata", bus.d_rdata, exp_d);
                if_pend = 1'b0; bus.if_req = 1'b0;
            end
        end
        chkb("rnd_if_drained", if_pend, 1'b0);
        chkb("rnd_d_drained", d_pend, 1'b0);
        chk("rnd_writes", 32'(wr_pulses), 32'(store_acks));
        cyc(); cyc();
        chkb("rnd_idle", bus.busy, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Sequences the single unified Memory of the multi-cycle CPU and shares it between two requesters: instruction fetch (IF) and data load/store (D).
- Latches one request at a time, drives the Memory's addr/din/mem_read/mem_write for a programmable number of cycles, captures read data, and returns a one-cycle ack to the winner.
- Sits between the control FSM/datapath and Memory; nothing else drives Memory.

Parameters:
- LATENCY, 2, cycles Memory is held per access (legal range 1..15).
- STARVE_LIMIT, 4, consecutive D grants with if_req pending before IF is forced to win (legal range 1..15).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- if_req  in  1  fetch request; held until if_ack.
- if_addr  in  32  fetch byte address; stable while if_req.
- if_rdata  out  32  fetched word; valid in the if_ack cycle, held until the next IF capture.
- if_ack  out  1  one-cycle completion pulse.
- d_req  in  1  data request; held until d_ack.
- d_we  in  1  1 = store, 0 = load; stable while d_req.
- d_addr  in  32  data byte address.
- d_wdata  in  32  store data.
- d_rdata  out  32  load data; valid in the d_ack cycle, held until the next D load capture.
- d_ack  out  1  one-cycle completion pulse.
- mem_addr  out  32  to Memory addr.
- mem_din  out  32  to Memory din.
- mem_read  out  1  to Memory mem_read.
- mem_write  out  1  to Memory mem_write.
- mem_dout  in  32  from Memory dout (asynchronous read).
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (async, any state, including mid-access): state=IDLE; all outputs 0 (if_rdata, d_rdata, mem_addr, mem_din included); wait counter=0; starve counter=0; owner=IF.
- States: IDLE, ACCESS, RESP.
- IDLE, arbitrating each cycle:
  - Neither request: stay.
  - Only one request: grant it.
  - Both requests: grant D, unless starve counter == STARVE_LIMIT, in which case grant IF.
  - On grant: latch owner, addr, wdata and we (IF grants always have we=0); load wait counter=LATENCY-1; go to ACCESS.
- Starve counter:
  - +1 (saturating at STARVE_LIMIT) on each D grant made while if_req=1.
  - Cleared on any IF grant.
  - Cleared on an IDLE cycle with if_req=0.
- ACCESS:
  - mem_addr and mem_din come from the latches.
  - mem_read = ~we for every ACCESS cycle.
  - mem_write = we only in the cycle where wait counter==0, so exactly one write per store.
  - Wait counter decrements each cycle. At counter==0, capture mem_dout into the owner's rdata register (loads/fetches only) and go to RESP.
  - mem_read/mem_write are 0 outside ACCESS. mem_addr/mem_din hold their last latched values.
- RESP: assert the owner's ack for exactly one cycle; the other ack stays 0. Next state is always IDLE.
- Timing: a request sampled in IDLE at edge t gives ACCESS for LATENCY cycles, ack in the following cycle, then IDLE. A back-to-back request has a period of LATENCY+2 cycles.
- Requests are sampled only in IDLE. A request asserted during ACCESS/RESP waits.
- A requester dropping req before ack is a protocol violation: the access still completes and ack still pulses.
- if_ack and d_ack are never high in the same cycle.
- rdata of the non-owner is never modified.
- Stores do not modify d_rdata.
- Addresses pass through unmodified; word alignment is handled by Memory.

Test Plan:
- Reset, then if_req=1, if_addr=0x0, Memory[0]=0x00500093, LATENCY=2 -> mem_read high for 2 cycles with mem_addr=0x0; if_ack pulses 1 cycle; if_rdata=0x00500093; busy low after.
- Store d_we=1, d_addr=0x100, d_wdata=0xDEADBEEF, then load from 0x100 -> mem_write high exactly 1 cycle; load d_rdata=0xDEADBEEF; if_rdata unchanged.
- if_req and d_req both high at the same edge -> D granted first (d_ack), IF acked next; acks 3 cycles apart for LATENCY=1.
- d_req held continuously with if_req high, STARVE_LIMIT=4 -> exactly 4 d_acks, then if_ack, then D resumes.
- Assert reset in the 2nd ACCESS cycle of a store -> all outputs 0 immediately; no mem_write pulse; after release, the pending request restarts from IDLE.
- LATENCY=1: if_req held high across the ack -> a new fetch is granted in the IDLE cycle after RESP; if_ack period = 3 cycles.
